// File: rtl/dm_pkg.sv
// dm_pkg: shared data-memory access-type codes and responder FSM encoding.
// Contents: DMType localparams (also imported by the CPU control decoder),
//           dm_state_t FSM encoding, and lane-width classification helpers.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    MERGE = 2'd2,
    ACK   = 2'd3
  } dm_state_t;

  function automatic logic dm_is_half(input logic [2:0] t);
    return (t == DM_HALF) || (t == DM_HALF_U);
  endfunction

  function automatic logic dm_is_byte(input logic [2:0] t);
    return (t == DM_BYTE) || (t == DM_BYTE_U);
  endfunction

  // Codes 101..111 fall through to word accesses.
  function automatic logic dm_is_word(input logic [2:0] t);
    return !(dm_is_half(t) || dm_is_byte(t));
  endfunction

endpackage

// File: rtl/dm_sram.sv
// dm_sram: single-port synchronous RAM, DEPTH x 32, one read or write per cycle.
// Latency: read data registered, valid the cycle after en & !we. No reset on storage.
// Ports: clk; en/we strobe; addr word index; wdata write word; rdata registered read word.
module dm_sram #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: MEM-stage load/store responder over a word SRAM (RMW for sub-word stores).
// Latency: word store rsp T+1; load and sub-word store rsp T+2; misaligned trap rsp T+1.
// Backpressure: req_ready only in IDLE; requests outside IDLE are ignored; rsp never held.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata/
//        req_dmtype request side; rsp_valid/rsp_rdata/rsp_err response side.
// Option: DM_MISALIGN_TRAP_EN turns misaligned half/word accesses into rsp_err responses.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [2:0]    req_dmtype,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IW = $clog2(DEPTH);

  dm_state_t state, state_nxt;

  // Holding registers captured at accept.
  logic          h_we;
  logic [1:0]    h_lane;
  logic [IW-1:0] h_idx;
  logic [15:0]   h_wdata;
  logic [2:0]    h_type;

  logic          sram_en, sram_we;
  logic [IW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [31:0]   merged, load_dat;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  logic          accept, req_word, req_mis;
  logic [IW-1:0] req_idx;
  logic          unused_addr;

  assign accept    = req_valid & req_ready;
  assign req_word  = dm_is_word(req_dmtype);
  assign req_idx   = req_addr[IW+1:2];
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == ACK);

  // Address bits above the word index wrap the address space.
  assign unused_addr = ^req_addr[AW-1:IW+2];

`ifdef DM_MISALIGN_TRAP_EN
  logic err_q;

  assign req_mis = (dm_is_half(req_dmtype) && req_addr[0]) ||
                   (req_word && (req_addr[1:0] != 2'b00));

  // Only meaningful in ACK; every path into ACK passes through an accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        err_q <= 1'b0;
    else if (accept) err_q <= req_mis;
  end
  assign rsp_err = err_q;
`else
  assign req_mis = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Lane extraction / merge on the word returned by the SRAM.
  // Halfword lane uses addr[1] only, so an odd half address is masked down.
  assign byte_sel = sram_rdata[{h_lane, 3'b000} +: 8];
  assign half_sel = sram_rdata[{h_lane[1], 4'b0000} +: 16];

  always_comb begin
    merged = sram_rdata;
    if (dm_is_byte(h_type)) merged[{h_lane, 3'b000} +: 8]        = h_wdata[7:0];
    else                    merged[{h_lane[1], 4'b0000} +: 16]   = h_wdata;
  end

  always_comb begin
    case (h_type)
      DM_HALF:   load_dat = {{16{half_sel[15]}}, half_sel};
      DM_HALF_U: load_dat = {16'h0000, half_sel};
      DM_BYTE:   load_dat = {{24{byte_sel[7]}}, byte_sel};
      DM_BYTE_U: load_dat = {24'h000000, byte_sel};
      default:   load_dat = sram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and SRAM port control. The MERGE write is driven from the state
  // register, so an asynchronous reset in MERGE cancels it before its edge.
  always_comb begin
    state_nxt  = state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = h_idx;
    sram_wdata = merged;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_mis) begin
            state_nxt = ACK;
          end else if (req_we && req_word) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = req_idx;
            sram_wdata = req_wdata;
            state_nxt  = ACK;
          end else begin
            sram_en   = 1'b1;
            sram_addr = req_idx;
            state_nxt = req_we ? MERGE : RD;
          end
        end
      end
      RD:    state_nxt = ACK;
      MERGE: begin
        sram_en   = 1'b1;
        sram_we   = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_we      <= 1'b0;
      h_lane    <= 2'b00;
      h_idx     <= '0;
      h_wdata   <= 16'h0000;
      h_type    <= DM_WORD;
      rsp_rdata <= 32'h0000_0000;
    end else begin
      if (accept) begin
        h_we    <= req_we;
        h_lane  <= req_addr[1:0];
        h_idx   <= req_idx;
        h_wdata <= req_wdata[15:0];
        h_type  <= req_dmtype;
        // Paths that go straight to ACK return zero data.
        if (req_mis || (req_we && req_word)) rsp_rdata <= 32'h0000_0000;
      end
      if (state == RD)    rsp_rdata <= h_we ? 32'h0000_0000 : load_dat;
      if (state == MERGE) rsp_rdata <= 32'h0000_0000;
    end
  end

  dm_sram #(.DEPTH(DEPTH), .IW(IW)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and randomized checks of dm_responder against a
// word-array reference model (lane arithmetic done with shifts and masks).
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_dmtype = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [0:1023];
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH(1024), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_dmtype (req_dmtype),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = word, 1 = half, 2 = byte
  function automatic int kind(input logic [2:0] t);
    if (t == 3'd1 || t == 3'd2) return 1;
    if (t == 3'd3 || t == 3'd4) return 2;
    return 0;
  endfunction

  function automatic bit ref_mis(input logic [2:0] t, input logic [1:0] lo);
    if (!TRAP) return 1'b0;
    if (kind(t) == 1) return lo[0];
    if (kind(t) == 0) return lo != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] t);
    logic [31:0] v;
    if (kind(t) == 2) begin
      v = (w >> (8 * lo)) & 32'hFF;
      if (t == 3'd3 && v >= 32'h80) v = v - 32'h100;
    end else if (kind(t) == 1) begin
      v = (w >> (16 * lo[1])) & 32'hFFFF;
      if (t == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] lo,
                                            input logic [2:0] t, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (kind(t) == 0) return d;
    if (kind(t) == 2) begin sh = 8 * lo;     m = 32'hFF;   end
    else              begin sh = 16 * lo[1]; m = 32'hFFFF; end
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  // Issue one request, wait for its response, check latency/data/err against the model.
  task automatic run_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] t);
    int n;
    int lat;
    logic [9:0]  idx;
    logic [31:0] exp_d;
    int exp_lat;
    bit mis;
    idx = addr[11:2];
    mis = ref_mis(t, addr[1:0]);
    exp_lat = (mis || (we && kind(t) == 0)) ? 1 : 2;
    exp_d = (mis || we) ? 32'h0 : ref_load(mdl[idx], addr[1:0], t);
    if (!mis && we) mdl[idx] = ref_store(mdl[idx], addr[1:0], t, wd);

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_dmtype = t;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_addr = $urandom;
    req_wdata = $urandom; req_dmtype = 3'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    last_rdata = rsp_rdata;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rsp_rdata, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(mis));
  endtask

  initial begin
    int pulses;
    logic [31:0] second_d;

    // Reset state
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Word store then load
    run_op("wst10", 1'b1, 32'h10, 32'hDEADBEEF, 3'd0);
    run_op("wld10", 1'b0, 32'h10, 32'h0, 3'd0);
    chk("wld10_const", last_rdata, 32'hDEADBEEF);

    // Sub-word merges, each load immediately after its store
    run_op("pre20", 1'b1, 32'h20, 32'h11223344, 3'd0);
    run_op("bst22", 1'b1, 32'h22, 32'h000000AA, 3'd3);
    run_op("ld20a", 1'b0, 32'h20, 32'h0, 3'd0);
    chk("ld20a_const", last_rdata, 32'h11AA3344);
    run_op("hst20", 1'b1, 32'h20, 32'h0000BEEF, 3'd1);
    run_op("ld20b", 1'b0, 32'h20, 32'h0, 3'd0);
    chk("ld20b_const", last_rdata, 32'h11AABEEF);

    // Load extension
    run_op("pre30", 1'b1, 32'h30, 32'h80F07F81, 3'd0);
    run_op("lbs30", 1'b0, 32'h30, 32'h0, 3'd3);
    chk("lbs30_const", last_rdata, 32'hFFFFFF81);
    run_op("lbu30", 1'b0, 32'h30, 32'h0, 3'd4);
    chk("lbu30_const", last_rdata, 32'h00000081);
    run_op("lhs32", 1'b0, 32'h32, 32'h0, 3'd1);
    chk("lhs32_const", last_rdata, 32'hFFFF80F0);
    run_op("lhu32", 1'b0, 32'h32, 32'h0, 3'd2);
    chk("lhu32_const", last_rdata, 32'h000080F0);

    // Busy: req_valid held high through RD/ACK with a second load pending
    @(negedge clk);
    chk("busy_idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_dmtype = 3'd0;
    @(negedge clk);
    chk("busy_rd_ready", 32'(req_ready), 32'd0);
    req_addr = 32'h20;
    @(negedge clk);
    chk("busy_ack_ready", 32'(req_ready), 32'd0);
    chk("busy_ack_valid", 32'(rsp_valid), 32'd1);
    chk("busy_ack_data", rsp_rdata, 32'hDEADBEEF);
    pulses = 1;
    @(negedge clk);
    chk("busy_idle2_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    second_d = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) begin pulses++; second_d = rsp_rdata; end
      @(negedge clk);
    end
    chk("busy_pulses", 32'(pulses), 32'd2);
    chk("busy_second_data", second_d, 32'h11AABEEF);

    // Reset during MERGE: the merge write must not happen
    run_op("pre40", 1'b1, 32'h40, 32'hCAFEF00D, 3'd0);
    run_op("ld40", 1'b0, 32'h40, 32'h0, 3'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h41; req_wdata = 32'h55; req_dmtype = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("merge_busy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(req_ready), 32'd1);
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rdata", rsp_rdata, 32'h0);
    chk("mrst_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_no_pulse", 32'(rsp_valid), 32'd0);
    run_op("ld40_after", 1'b0, 32'h40, 32'h0, 3'd0);
    chk("ld40_after_const", last_rdata, 32'hCAFEF00D);

    // Reset during ACK of a word store: the write already happened
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'h12345678; req_dmtype = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wack_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("wack_rst_valid", 32'(rsp_valid), 32'd0);
    mdl[10'h14] = 32'h12345678;
    @(negedge clk);
    rst = 1'b1;
    run_op("ld50", 1'b0, 32'h50, 32'h0, 3'd0);
    chk("ld50_const", last_rdata, 32'h12345678);

    // Misaligned word load
    run_op("mis41", 1'b0, 32'h41, 32'h0, 3'd0);
    chk("mis41_const", last_rdata, TRAP ? 32'h0 : 32'hCAFEF00D);

    // Randomized traffic over 16 words, upper address bits randomized (wrap)
    for (int i = 0; i < 16; i++)
      run_op("rinit", 1'b1, 32'(i * 4), $urandom, 3'd0);
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFFF000) | 32'(($urandom % 16) * 4) | 32'($urandom % 4);
      run_op("rand", 1'($urandom), a, $urandom, 3'($urandom));
    end
    for (int i = 0; i < 16; i++)
      run_op("rfinal", 1'b0, 32'(i * 4), 32'h0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
